// File: rtl/sub_32bit_pipe_pkg.sv
// Shared arithmetic constants for the pipelined subtractor: half-width
// derivation and the elaboration-time width legality check.
package sub_32bit_pipe_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int MIN_WIDTH     = 4;

    // Each pipeline stage handles one half of the operand.
    function automatic int half_of(input int width);
        return width / 2;
    endfunction

    // The split datapath needs an even width with at least two bits per half.
    function automatic bit width_ok(input int width);
        return (width >= MIN_WIDTH) && ((width % 2) == 0);
    endfunction

endpackage

// File: rtl/sub_half_stage.sv
// HALF-wide subtract with borrow-in/borrow-out. The combinational result is
// exposed for flag logic; the registered copy loads only when en is high.
module sub_half_stage #(
    parameter int HALF = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [HALF-1:0] a,
    input  logic [HALF-1:0] b,
    input  logic            bin,
    output logic [HALF-1:0] diff_nxt,
    output logic            bout_nxt,
    output logic [HALF-1:0] diff,
    output logic            bout
);

    logic [HALF:0] full;

    // Zero-extended subtract: the extra top bit is the borrow out of the slice.
    assign full     = {1'b0, a} - {1'b0, b} - {{HALF{1'b0}}, bin};
    assign diff_nxt = full[HALF-1:0];
    assign bout_nxt = full[HALF];

    always_ff @(posedge clk) begin
        if (rst) begin
            diff <= '0;
            bout <= 1'b0;
        end else if (en) begin
            diff <= diff_nxt;
            bout <= bout_nxt;
        end
    end

endmodule

// File: rtl/sub_32bit_pipe.sv
// Two-stage handshaked subtractor: diff = a - b - bin. Stage 1 computes the
// low half, stage 2 consumes its registered borrow to finish the high half.
module sub_32bit_pipe
    import sub_32bit_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int HALF = half_of(WIDTH);

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("sub_32bit_pipe: WIDTH must be even and >= 4");
        end
    endgenerate

    // Handshake: a beat moves across an interface on the cycle where both
    // valid and ready are high at the rising edge; valid never waits on ready,
    // and a presented result holds stable until it is taken.
    logic s1_valid;
    logic s2_valid;
    logic s2_free;
    logic s1_adv;
    logic in_fire;

    assign s2_free   = ~s2_valid | out_ready;
    assign s1_adv    = s1_valid & s2_free;
    assign in_ready  = ~rst & (~s1_valid | s2_free);
    assign in_fire   = in_valid & in_ready;
    assign out_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (in_fire)
                s1_valid <= 1'b1;
            else if (s1_adv)
                s1_valid <= 1'b0;

            if (s1_adv)
                s2_valid <= 1'b1;
            else if (out_ready)
                s2_valid <= 1'b0;
        end
    end

    // Stage 1: low half plus the high operand halves carried forward.
    logic [HALF-1:0] s1_diff_nxt;
    logic            s1_bout_nxt_unused;
    logic [HALF-1:0] diff_lo_s1;
    logic            borrow1;
    logic [HALF-1:0] a_hi_q;
    logic [HALF-1:0] b_hi_q;
    logic            lo_zero_q;

    sub_half_stage #(.HALF(HALF)) u_stage_lo (
        .clk      (clk),
        .rst      (rst),
        .en       (in_fire),
        .a        (a[HALF-1:0]),
        .b        (b[HALF-1:0]),
        .bin      (bin),
        .diff_nxt (s1_diff_nxt),
        .bout_nxt (s1_bout_nxt_unused),
        .diff     (diff_lo_s1),
        .bout     (borrow1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_hi_q    <= '0;
            b_hi_q    <= '0;
            lo_zero_q <= 1'b0;
        end else if (in_fire) begin
            a_hi_q    <= a[WIDTH-1:HALF];
            b_hi_q    <= b[WIDTH-1:HALF];
            lo_zero_q <= (s1_diff_nxt == '0);
        end
    end

    // Stage 2: high half with the stage-1 borrow; its borrow is the full borrow.
    logic [HALF-1:0] diff_hi_nxt;
    logic            s2_bout_nxt_unused;
    logic [HALF-1:0] diff_hi_q;
    logic [HALF-1:0] diff_lo_s2;
    logic            bout_q;
    logic            ovf_q;
    logic            zero_q;

    sub_half_stage #(.HALF(HALF)) u_stage_hi (
        .clk      (clk),
        .rst      (rst),
        .en       (s1_adv),
        .a        (a_hi_q),
        .b        (b_hi_q),
        .bin      (borrow1),
        .diff_nxt (diff_hi_nxt),
        .bout_nxt (s2_bout_nxt_unused),
        .diff     (diff_hi_q),
        .bout     (bout_q)
    );

    // Signed overflow: operand signs differ and the result sign leaves a's.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_lo_s2 <= '0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else if (s1_adv) begin
            diff_lo_s2 <= diff_lo_s1;
            ovf_q      <= (a_hi_q[HALF-1] ^ b_hi_q[HALF-1]) &
                          (diff_hi_nxt[HALF-1] ^ a_hi_q[HALF-1]);
            zero_q     <= lo_zero_q & (diff_hi_nxt == '0);
        end
    end

    assign diff = {diff_hi_q, diff_lo_s2};
    assign bout = bout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_sub_32bit_pipe.sv
// Directed bench for sub_32bit_pipe: reset, cross-half borrow, wrap, signed
// overflow/zero, back-pressure with in-order drain, and mid-flight reset.
module tb_sub_32bit_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    int checks = 0;
    int errors = 0;

    // Expected results packed as {bout, ovf, zero, diff}.
    logic [W+2:0] exp_q[$];

    sub_32bit_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Drivers: inputs change just after the falling edge.
    task automatic drive_beat(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in);
        @(negedge clk);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        bin      = bv_in;
        #1;
    endtask

    task automatic drive_idle();
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        bin      = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_low got=%b want=0", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready_high got=%b want=1", in_ready);
        end
        checks++;
        if ({out_valid, diff, bout, ovf, zero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%h bo=%b ov=%b z=%b want all 0",
                     out_valid, diff, bout, ovf, zero);
        end
    endtask

    task automatic test_cross_half();
        out_ready = 1'b1;
        drive_beat(32'h0001_0000, 32'h0000_0001, 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL cross_in_ready got=%b want=1", in_ready);
        end
        drive_idle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL cross_early_valid got=%b want=0", out_valid);
        end
        drive_idle();
        checks++;
        if ({out_valid, diff, bout, ovf, zero} !== {1'b1, 32'h0000_FFFF, 3'b000}) begin
            errors++;
            $display("FAIL cross_result got v=%b d=%h bo=%b ov=%b z=%b want v=1 d=0000ffff 0/0/0",
                     out_valid, diff, bout, ovf, zero);
        end
        drive_idle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL cross_duplicate got=%b want=0", out_valid);
        end
    endtask

    task automatic test_underflow();
        out_ready = 1'b1;
        drive_beat(32'h0, 32'h1, 1'b0);
        drive_beat(32'h0, 32'h0, 1'b1);
        drive_idle();
        checks++;
        if ({out_valid, diff, bout, ovf, zero} !== {1'b1, 32'hFFFF_FFFF, 3'b100}) begin
            errors++;
            $display("FAIL underflow_b1 got v=%b d=%h bo=%b ov=%b z=%b want v=1 d=ffffffff 1/0/0",
                     out_valid, diff, bout, ovf, zero);
        end
        drive_idle();
        checks++;
        if ({out_valid, diff, bout, ovf, zero} !== {1'b1, 32'hFFFF_FFFF, 3'b100}) begin
            errors++;
            $display("FAIL underflow_bin got v=%b d=%h bo=%b ov=%b z=%b want v=1 d=ffffffff 1/0/0",
                     out_valid, diff, bout, ovf, zero);
        end
        drive_idle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL underflow_drain got=%b want=0", out_valid);
        end
    endtask

    task automatic test_ovf_zero();
        out_ready = 1'b1;
        drive_beat(32'h8000_0000, 32'h0000_0001, 1'b0);
        drive_beat(32'h1234_5678, 32'h1234_5678, 1'b0);
        drive_idle();
        checks++;
        if ({out_valid, diff, bout, ovf, zero} !== {1'b1, 32'h7FFF_FFFF, 3'b010}) begin
            errors++;
            $display("FAIL ovf_result got v=%b d=%h bo=%b ov=%b z=%b want v=1 d=7fffffff 0/1/0",
                     out_valid, diff, bout, ovf, zero);
        end
        drive_idle();
        checks++;
        if ({out_valid, diff, bout, ovf, zero} !== {1'b1, 32'h0, 3'b001}) begin
            errors++;
            $display("FAIL zero_result got v=%b d=%h bo=%b ov=%b z=%b want v=1 d=00000000 0/0/1",
                     out_valid, diff, bout, ovf, zero);
        end
    endtask

    task automatic test_back_pressure();
        logic [W-1:0] ta[7];
        logic [W-1:0] tb_[7];
        logic         tbin[7];
        logic [W+2:0] texp[7];
        logic [W+2:0] got;
        int fed;
        int received;
        int first_cyc;
        int last_cyc;

        ta[0] = 32'd10;        tb_[0] = 32'd3;         tbin[0] = 1'b0; texp[0] = {3'b000, 32'h0000_0007};
        ta[1] = 32'd3;         tb_[1] = 32'd10;        tbin[1] = 1'b0; texp[1] = {3'b100, 32'hFFFF_FFF9};
        ta[2] = 32'h0000_0100; tb_[2] = 32'h0000_0100; tbin[2] = 1'b0; texp[2] = {3'b001, 32'h0000_0000};
        ta[3] = 32'h7FFF_FFFF; tb_[3] = 32'hFFFF_FFFF; tbin[3] = 1'b0; texp[3] = {3'b110, 32'h8000_0000};
        ta[4] = 32'hFFFF_0000; tb_[4] = 32'h0000_FFFF; tbin[4] = 1'b1; texp[4] = {3'b000, 32'hFFFE_0000};
        ta[5] = 32'h0001_0000; tb_[5] = 32'h0000_0000; tbin[5] = 1'b1; texp[5] = {3'b000, 32'h0000_FFFF};
        ta[6] = 32'h5555_5555; tb_[6] = 32'h1111_1111; tbin[6] = 1'b1; texp[6] = {3'b000, 32'h4444_4443};
        for (int i = 0; i < 7; i++) exp_q.push_back(texp[i]);

        out_ready = 1'b0;
        drive_beat(ta[0], tb_[0], tbin[0]);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept0 got=%b want=1", in_ready);
        end
        drive_beat(ta[1], tb_[1], tbin[1]);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept1 got=%b want=1", in_ready);
        end
        drive_beat(ta[2], tb_[2], tbin[2]);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got=%b want=0", in_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({out_valid, bout, ovf, zero, diff} !== {1'b1, texp[0]}) begin
            errors++;
            $display("FAIL bp_hold got v=%b d=%h want v=1 d=%h", out_valid, diff, texp[0][W-1:0]);
        end

        // Release: beat 2 is still presented and must be taken now.
        fed       = 2;
        received  = 0;
        first_cyc = -1;
        last_cyc  = -1;
        out_ready = 1'b1;
        #1;
        for (int cyc = 0; cyc < 30 && received < 7; cyc++) begin
            if (out_valid === 1'b1) begin
                got = {bout, ovf, zero, diff};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra_beat got d=%h want none", diff);
                end else if (got !== exp_q[0]) begin
                    errors++;
                    $display("FAIL bp_order got=%h want=%h", got, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
                received++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) fed++;
            @(negedge clk);
            if (fed < 7) begin
                in_valid = 1'b1;
                a        = ta[fed];
                b        = tb_[fed];
                bin      = tbin[fed];
            end else begin
                in_valid = 1'b0;
            end
            #1;
        end
        checks++;
        if (received != 7 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_count got=%0d left=%0d want=7 left=0", received, exp_q.size());
        end
        checks++;
        if (last_cyc - first_cyc + 1 != 7) begin
            errors++;
            $display("FAIL bp_throughput got span=%0d want=7", last_cyc - first_cyc + 1);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        drive_beat(32'd50, 32'd20, 1'b0);
        drive_beat(32'd70, 32'd20, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_in_ready got=%b want=0", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, diff, bout, ovf, zero} !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_outputs got v=%b d=%h bo=%b ov=%b z=%b rdy=%b want 0s rdy=1",
                     out_valid, diff, bout, ovf, zero, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_idle();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_stale cyc=%0d got d=%h want no beat", i, diff);
            end
        end
        drive_beat(32'd100, 32'd58, 1'b0);
        drive_idle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_early got=%b want=0", out_valid);
        end
        drive_idle();
        checks++;
        if ({out_valid, diff, bout, ovf, zero} !== {1'b1, 32'd42, 3'b000}) begin
            errors++;
            $display("FAIL rst_mid_new got v=%b d=%h bo=%b ov=%b z=%b want v=1 d=0000002a 0/0/0",
                     out_valid, diff, bout, ovf, zero);
        end
    endtask

    initial begin
        test_reset();
        test_cross_half();
        test_underflow();
        test_ovf_zero();
        drive_idle();
        drive_idle();
        test_back_pressure();
        drive_idle();
        drive_idle();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog: the directed sequence is short, so this only trips on a hang.
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
